// File: rtl/ship_pkg.sv
// ship_pkg: shared state encoding and frame timer sizing for ship_lifecycle_ctrl.
// The INVULN state exists only when SHIP_INVULN_EN is defined.
package ship_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SPAWN     = 3'd1,
`ifdef SHIP_INVULN_EN
        S_INVULN    = 3'd2,
`endif
        S_ALIVE     = 3'd3,
        S_EXPLODE   = 3'd4,
        S_WAIT      = 3'd5,
        S_GAME_OVER = 3'd6
    } ship_state_t;

    function automatic int timer_width(input int e, input int r, input int i);
        int m;
        m = (e > r) ? e : r;
        m = (m > i) ? m : i;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/ship_lifecycle_ctrl_if.sv
// ship_lifecycle_ctrl_if: keypad/collision inputs and ship datapath controls.
// master drives the raw inputs, slave is the lifecycle controller.
interface ship_lifecycle_ctrl_if #(
    parameter int LW = 2
) ();
    logic          frame_tick;
    logic          start;
    logic          collision;
    logic          thrust_btn;
    logic          fire_btn;
    logic          thrust_en;
    logic          fire_en;
    logic          ship_respawn;
    logic          ship_visible;
    logic          exploding;
    logic          game_over;
    logic [LW-1:0] lives_left;

    modport master (
        output frame_tick, start, collision, thrust_btn, fire_btn,
        input  thrust_en, fire_en, ship_respawn, ship_visible, exploding, game_over, lives_left
    );

    modport slave (
        input  frame_tick, start, collision, thrust_btn, fire_btn,
        output thrust_en, fire_en, ship_respawn, ship_visible, exploding, game_over, lives_left
    );
endinterface

// File: rtl/ship_lifecycle_ctrl_frame_timer.sv
// frame_timer: frame counter cleared on state entry; done flags the tick that reaches limit.
module frame_timer #(
    parameter int TW = 7
) (
    input  logic          clk,
    input  logic          resetN,
    input  logic          clear,
    input  logic          tick,
    input  logic [TW-1:0] limit,
    output logic [TW-1:0] count,
    output logic          done
);
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) count <= '0;
        else         count <= clear ? '0 : count + TW'(tick);
    end

    assign done = tick && (count == limit);
endmodule

// File: rtl/ship_lifecycle_ctrl.sv
// ship_lifecycle_ctrl: player ship lifecycle FSM gating thrust/fire and driving sprite enables.
// Define SHIP_INVULN_EN to add the blinking post-spawn invulnerability state.
module ship_lifecycle_ctrl
    import ship_pkg::*;
#(
    parameter int LIVES          = 3,
    parameter int EXPLODE_FRAMES = 60,
    parameter int RESPAWN_FRAMES = 30,
    parameter int INVULN_FRAMES  = 120,
    parameter int BLINK_SHIFT    = 3
) (
    input logic                  clk,
    input logic                  resetN,
    ship_lifecycle_ctrl_if.slave bus
);
    localparam int LW = $clog2(LIVES + 1);
    localparam int TW = timer_width(EXPLODE_FRAMES, RESPAWN_FRAMES, INVULN_FRAMES);

    if (BLINK_SHIFT >= TW) begin : g_blink_chk
        $error("BLINK_SHIFT must index a frame timer bit");
    end

    ship_state_t   state, state_nxt;
    logic [LW-1:0] lives, lives_nxt;
    logic [TW-1:0] count, limit;
    logic          start_q, start_rise, done, active, thrust_q, fire_q;

    assign start_rise = bus.start & ~start_q;

`ifdef SHIP_INVULN_EN
    assign active           = (state == S_INVULN) || (state == S_ALIVE);
    assign limit            = (state == S_EXPLODE) ? TW'(EXPLODE_FRAMES - 1) :
                              (state == S_WAIT)    ? TW'(RESPAWN_FRAMES - 1) : TW'(INVULN_FRAMES - 1);
    assign bus.ship_visible = (state == S_ALIVE) || ((state == S_INVULN) && !count[BLINK_SHIFT]);
`else
    assign active           = (state == S_ALIVE);
    assign limit            = (state == S_EXPLODE) ? TW'(EXPLODE_FRAMES - 1) : TW'(RESPAWN_FRAMES - 1);
    assign bus.ship_visible = (state == S_ALIVE);
`endif

    frame_timer #(.TW(TW)) u_timer (
        .clk    (clk),
        .resetN (resetN),
        .clear  (state_nxt != state),
        .tick   (bus.frame_tick),
        .limit  (limit),
        .count  (count),
        .done   (done)
    );

    always_comb begin
        state_nxt = state;
        lives_nxt = lives;
        case (state)
            S_IDLE, S_GAME_OVER: if (start_rise) begin
                state_nxt = S_SPAWN;
                lives_nxt = LW'(LIVES);
            end
`ifdef SHIP_INVULN_EN
            S_SPAWN:  state_nxt = S_INVULN;
            S_INVULN: if (done) state_nxt = S_ALIVE;
`else
            S_SPAWN:  state_nxt = S_ALIVE;
`endif
            S_ALIVE: if (bus.collision) begin
                state_nxt = S_EXPLODE;
                lives_nxt = (lives != '0) ? lives - 1'b1 : lives;
            end
            S_EXPLODE: if (done) state_nxt = (lives == '0) ? S_GAME_OVER : S_WAIT;
            S_WAIT:    if (done) state_nxt = S_SPAWN;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state    <= S_IDLE;
            lives    <= '0;
            start_q  <= 1'b0;
            thrust_q <= 1'b0;
            fire_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            lives    <= lives_nxt;
            start_q  <= bus.start;
            thrust_q <= bus.thrust_btn & active;
            fire_q   <= bus.fire_btn & active;
        end
    end

    assign bus.thrust_en    = thrust_q;
    assign bus.fire_en      = fire_q;
    assign bus.ship_respawn = (state == S_SPAWN);
    assign bus.exploding    = (state == S_EXPLODE);
    assign bus.game_over    = (state == S_GAME_OVER);
    assign bus.lives_left   = lives;
endmodule
